// File: rtl/bcd_time_pkg.sv
// bcd_time_pkg: shared helpers for packed-BCD time/date fields.
//   rpt_state_t  - per-button auto-repeat state
//   bcd_inc      - packed-BCD +1 (caller handles the upper limit)
//   bcd_dec      - packed-BCD -1 (caller handles the lower limit)
//   bcd_valid    - both nibbles are decimal digits
//   bcd_in_range - lo <= v <= hi (packed BCD compares like binary)
package bcd_time_pkg;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_WAIT   = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_t;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v[3:0] == 4'd0)
            return {v[7:4] - 4'd1, 4'd9};
        else
            return {v[7:4], v[3:0] - 4'd1};
    endfunction

    function automatic logic bcd_valid(input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    function automatic logic bcd_in_range(input logic [7:0] v,
                                          input logic [7:0] lo,
                                          input logic [7:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/bcd_time_field_btn_step_gen.sv
// btn_step_gen: turns one synchronised button level into step pulses.
//   CLK, RST - clock, synchronous active-high reset
//   BTN      - button level
//   EN       - edit mode; no steps while low
//   CANCEL   - opposite button has just risen (drops this button's repeat)
//   RISE     - qualified rising edge this cycle
//   STEP     - one-cycle step request
// Optional feature macro: AUTOREPEAT_EN (hold-to-repeat FSM and counter).
module btn_step_gen
    import bcd_time_pkg::*;
#(
    parameter logic [15:0] REP_DLY = 16'd50000,
    parameter logic [15:0] REP_PER = 16'd10000
) (
    input  logic CLK,
    input  logic RST,
    input  logic BTN,
    input  logic EN,
    input  logic CANCEL,
    output logic RISE,
    output logic STEP
);

    logic prev;
    // A button must be seen released after reset before it can produce an
    // edge, so a button held through reset does not step on release of RST.
    logic armed;

    always_ff @(posedge CLK) begin
        if (RST) begin
            prev  <= 1'b0;
            armed <= 1'b0;
        end else begin
            prev <= BTN;
            if (!BTN)
                armed <= 1'b1;
        end
    end

    // prev tracks BTN even outside edit mode, so a button already held when
    // EN rises is not an edge.
    assign RISE = EN && BTN && !prev && armed;

`ifdef AUTOREPEAT_EN
    rpt_state_t  state;
    logic [15:0] cnt;
    logic        hold_ok;
    logic        rpt_step;

    assign hold_ok = BTN && EN && !CANCEL;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= RPT_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                RPT_IDLE: begin
                    if (RISE && !CANCEL) begin
                        state <= RPT_WAIT;
                        cnt   <= '0;
                    end
                end
                RPT_WAIT: begin
                    if (!hold_ok) begin
                        state <= RPT_IDLE;
                    end else if (cnt == REP_DLY - 16'd1) begin
                        state <= RPT_REPEAT;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                RPT_REPEAT: begin
                    if (!hold_ok)
                        state <= RPT_IDLE;
                    else if (cnt == REP_PER - 16'd1)
                        cnt <= '0;
                    else
                        cnt <= cnt + 16'd1;
                end
                default: state <= RPT_IDLE;
            endcase
        end
    end

    always_comb begin
        rpt_step = 1'b0;
        case (state)
            RPT_WAIT:   rpt_step = hold_ok && (cnt == REP_DLY - 16'd1);
            RPT_REPEAT: rpt_step = hold_ok && (cnt == REP_PER - 16'd1);
            default:    rpt_step = 1'b0;
        endcase
    end

    assign STEP = (RISE && !CANCEL) || rpt_step;
`else
    // Repeat timing only matters when the repeat FSM is built.
    logic unused_rep_cfg;
    assign unused_rep_cfg = ^{REP_DLY, REP_PER};

    assign STEP = RISE && !CANCEL;
`endif

endmodule

// File: rtl/bcd_time_field.sv
// bcd_time_field: one editable packed-BCD time/date field (seconds, hours,
// day, ...) selected by MIN_VAL/MAX_VAL/WRAP.
//   CLK, RST     - clock, synchronous active-high reset
//   UP, DOWN     - step request levels (already synchronised)
//   Modificando  - edit mode; steps only apply while high
//   Actualizar   - load DATA_in when not editing
//   DATA_in      - packed-BCD value from the RTC
//   DATA_out     - registered field value
//   CARRY/BORROW - one-cycle pulse on wrap up / wrap down
//   DIRTY        - edited since last successful load
//   LOAD_ERR     - one-cycle pulse when DATA_in is rejected
// Optional feature macro: AUTOREPEAT_EN (hold-to-repeat on both buttons).
module bcd_time_field
    import bcd_time_pkg::*;
#(
    parameter logic [7:0]  MIN_VAL = 8'h00,
    parameter logic [7:0]  MAX_VAL = 8'h59,
    parameter bit          WRAP    = 1'b1,
    parameter logic [15:0] REP_DLY = 16'd50000,
    parameter logic [15:0] REP_PER = 16'd10000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       UP,
    input  logic       DOWN,
    input  logic       Modificando,
    input  logic       Actualizar,
    input  logic [7:0] DATA_in,
    output logic [7:0] DATA_out,
    output logic       CARRY,
    output logic       BORROW,
    output logic       DIRTY,
    output logic       LOAD_ERR
);

    logic up_rise, down_rise;
    logic up_step, down_step;

    // UP wins a simultaneous press: DOWN is cancelled by an UP edge, UP is
    // only cancelled by a DOWN edge that arrives on its own.
    btn_step_gen #(.REP_DLY(REP_DLY), .REP_PER(REP_PER)) u_up (
        .CLK    (CLK),
        .RST    (RST),
        .BTN    (UP),
        .EN     (Modificando),
        .CANCEL (down_rise && !up_rise),
        .RISE   (up_rise),
        .STEP   (up_step)
    );

    btn_step_gen #(.REP_DLY(REP_DLY), .REP_PER(REP_PER)) u_down (
        .CLK    (CLK),
        .RST    (RST),
        .BTN    (DOWN),
        .EN     (Modificando),
        .CANCEL (up_rise),
        .RISE   (down_rise),
        .STEP   (down_step)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            DATA_out <= MIN_VAL;
            CARRY    <= 1'b0;
            BORROW   <= 1'b0;
            DIRTY    <= 1'b0;
            LOAD_ERR <= 1'b0;
        end else begin
            CARRY    <= 1'b0;
            BORROW   <= 1'b0;
            LOAD_ERR <= 1'b0;
            if (Modificando) begin
                if (up_step) begin
                    DIRTY <= 1'b1;
                    if (DATA_out == MAX_VAL) begin
                        if (WRAP) begin
                            DATA_out <= MIN_VAL;
                            CARRY    <= 1'b1;
                        end
                    end else begin
                        DATA_out <= bcd_inc(DATA_out);
                    end
                end else if (down_step) begin
                    DIRTY <= 1'b1;
                    if (DATA_out == MIN_VAL) begin
                        if (WRAP) begin
                            DATA_out <= MAX_VAL;
                            BORROW   <= 1'b1;
                        end
                    end else begin
                        DATA_out <= bcd_dec(DATA_out);
                    end
                end
            end else if (Actualizar) begin
                if (bcd_valid(DATA_in) && bcd_in_range(DATA_in, MIN_VAL, MAX_VAL)) begin
                    DATA_out <= DATA_in;
                    DIRTY    <= 1'b0;
                end else begin
                    LOAD_ERR <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_time_field.sv
module tb_bcd_time_field;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Field A: seconds 00-59, wrapping, short repeat timing.
    logic       rst_a, up_a, down_a, mod_a, act_a;
    logic [7:0] din_a, dout_a;
    logic       carry_a, borrow_a, dirty_a, lerr_a;
    // Field B: day 01-31, saturating.
    logic       rst_b, up_b, down_b, mod_b, act_b;
    logic [7:0] din_b, dout_b;
    logic       carry_b, borrow_b, dirty_b, lerr_b;

    bcd_time_field #(
        .MIN_VAL(8'h00), .MAX_VAL(8'h59), .WRAP(1'b1),
        .REP_DLY(16'd4), .REP_PER(16'd2)
    ) dut_a (
        .CLK(clk), .RST(rst_a), .UP(up_a), .DOWN(down_a),
        .Modificando(mod_a), .Actualizar(act_a), .DATA_in(din_a),
        .DATA_out(dout_a), .CARRY(carry_a), .BORROW(borrow_a),
        .DIRTY(dirty_a), .LOAD_ERR(lerr_a)
    );

    bcd_time_field #(
        .MIN_VAL(8'h01), .MAX_VAL(8'h31), .WRAP(1'b0)
    ) dut_b (
        .CLK(clk), .RST(rst_b), .UP(up_b), .DOWN(down_b),
        .Modificando(mod_b), .Actualizar(act_b), .DATA_in(din_b),
        .DATA_out(dout_b), .CARRY(carry_b), .BORROW(borrow_b),
        .DIRTY(dirty_b), .LOAD_ERR(lerr_b)
    );

    typedef struct {
        logic       rst, up, down, mod, act;
        logic [7:0] din;
        logic [7:0] d;
        logic       c, b, dy, le;
    } vec_t;

    typedef struct {
        bit         sel;
        string      nm;
        logic [7:0] d;
        logic       c, b, dy, le;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic vec_t mk(input logic rst, input logic up, input logic down,
                                input logic mod, input logic act, input logic [7:0] din,
                                input logic [7:0] d, input logic c, input logic b,
                                input logic dy, input logic le);
        vec_t v;
        v.rst = rst; v.up = up; v.down = down; v.mod = mod; v.act = act;
        v.din = din; v.d = d; v.c = c; v.b = b; v.dy = dy; v.le = le;
        return v;
    endfunction

    // Drive one cycle of stimulus on field A (sel=0) or B (sel=1), queue the
    // expected outputs, then pop and compare after the clock edge.
    task automatic run(input bit sel, input vec_t v, input string nm);
        exp_t e;
        exp_t got;
        logic [11:0] act_o, exp_o;
        @(negedge clk);
        if (!sel) begin
            rst_a = v.rst; up_a = v.up; down_a = v.down;
            mod_a = v.mod; act_a = v.act; din_a = v.din;
        end else begin
            rst_b = v.rst; up_b = v.up; down_b = v.down;
            mod_b = v.mod; act_b = v.act; din_b = v.din;
        end
        e.sel = sel; e.nm = nm; e.d = v.d; e.c = v.c; e.b = v.b; e.dy = v.dy; e.le = v.le;
        sb.push_back(e);
        @(posedge clk);
        #1;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL %s scoreboard empty", nm);
        end else begin
            got = sb.pop_front();
            if (!got.sel) act_o = {dout_a, carry_a, borrow_a, dirty_a, lerr_a};
            else          act_o = {dout_b, carry_b, borrow_b, dirty_b, lerr_b};
            exp_o = {got.d, got.c, got.b, got.dy, got.le};
            if (act_o !== exp_o) begin
                failures++;
                $display("FAIL %s got data=%h c=%b b=%b dirty=%b lerr=%b expected data=%h c=%b b=%b dirty=%b lerr=%b",
                         got.nm, act_o[11:4], act_o[3], act_o[2], act_o[1], act_o[0],
                         exp_o[11:4], exp_o[3], exp_o[2], exp_o[1], exp_o[0]);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[$];
        logic [7:0] rep_exp [10];

        rst_a = 1'b1; up_a = 1'b0; down_a = 1'b0; mod_a = 1'b0; act_a = 1'b0; din_a = 8'h00;
        rst_b = 1'b1; up_b = 1'b0; down_b = 1'b0; mod_b = 1'b0; act_b = 1'b0; din_b = 8'h00;

        //                  rst up dn mod act din     data   c  b  dy le
        tbl.push_back(mk(1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0)); // reset
        tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 8'h59, 8'h59, 0, 0, 0, 0)); // load 59
        tbl.push_back(mk(0, 0, 0, 1, 0, 8'h00, 8'h59, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 0, 8'h00, 8'h00, 1, 0, 1, 0)); // 59 -> 00 carry
        tbl.push_back(mk(0, 0, 0, 1, 0, 8'h00, 8'h00, 0, 0, 1, 0)); // carry one cycle
        tbl.push_back(mk(0, 0, 1, 1, 0, 8'h00, 8'h59, 0, 1, 1, 0)); // 00 -> 59 borrow
        tbl.push_back(mk(0, 0, 0, 1, 0, 8'h00, 8'h59, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 1, 1, 0, 8'h00, 8'h00, 1, 0, 1, 0)); // both: UP wins
        tbl.push_back(mk(0, 0, 0, 1, 0, 8'h00, 8'h00, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 8'h37, 8'h00, 0, 0, 1, 0)); // load ignored in edit
        tbl.push_back(mk(0, 0, 0, 0, 1, 8'h4A, 8'h00, 0, 0, 1, 1)); // non-BCD rejected
        tbl.push_back(mk(0, 0, 0, 0, 1, 8'h60, 8'h00, 0, 0, 1, 1)); // above max rejected
        tbl.push_back(mk(0, 0, 0, 0, 1, 8'h37, 8'h37, 0, 0, 0, 0)); // good load clears dirty
        tbl.push_back(mk(0, 1, 0, 0, 0, 8'h00, 8'h37, 0, 0, 0, 0)); // UP outside edit ignored
        tbl.push_back(mk(0, 1, 0, 1, 0, 8'h00, 8'h37, 0, 0, 0, 0)); // held at entry: no step
        tbl.push_back(mk(0, 0, 0, 1, 0, 8'h00, 8'h37, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 0, 8'h00, 8'h38, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 8'h00, 8'h38, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 8'h00, 8'h37, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 8'h00, 8'h37, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 8'h19, 8'h19, 0, 0, 0, 0)); // load 19
        tbl.push_back(mk(0, 0, 0, 1, 0, 8'h00, 8'h19, 0, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++)
            run(1'b0, tbl[i], $sformatf("a_vec%0d", i));

`ifndef AUTOREPEAT_EN
        // Long holds give exactly one step each way.
        for (int i = 0; i < 100; i++)
            run(1'b0, mk(0, 1, 0, 1, 0, 8'h00, 8'h20, 0, 0, 1, 0), $sformatf("a_hold_up%0d", i));
        run(1'b0, mk(0, 0, 0, 1, 0, 8'h00, 8'h20, 0, 0, 1, 0), "a_rel_up");
        for (int i = 0; i < 100; i++)
            run(1'b0, mk(0, 0, 1, 1, 0, 8'h00, 8'h19, 0, 0, 1, 0), $sformatf("a_hold_dn%0d", i));
        run(1'b0, mk(0, 0, 0, 1, 0, 8'h00, 8'h19, 0, 0, 1, 0), "a_rel_dn");
`else
        // Edge step, then REP_DLY=4 held cycles, then every REP_PER=2 cycles.
        rep_exp = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h02, 8'h02, 8'h03, 8'h03, 8'h04, 8'h04};
        run(1'b0, mk(0, 0, 0, 0, 1, 8'h00, 8'h00, 0, 0, 0, 0), "a_load00");
        run(1'b0, mk(0, 0, 0, 1, 0, 8'h00, 8'h00, 0, 0, 0, 0), "a_enter");
        for (int i = 0; i < 10; i++)
            run(1'b0, mk(0, 1, 0, 1, 0, 8'h00, rep_exp[i], 0, 0, 1, 0), $sformatf("a_rep%0d", i));
        run(1'b0, mk(1, 1, 0, 1, 0, 8'h00, 8'h00, 0, 0, 0, 0), "a_rst_in_repeat");
        for (int i = 0; i < 10; i++)
            run(1'b0, mk(0, 1, 0, 1, 0, 8'h00, 8'h00, 0, 0, 0, 0), $sformatf("a_post_rst%0d", i));
        run(1'b0, mk(0, 0, 0, 1, 0, 8'h00, 8'h00, 0, 0, 0, 0), "a_post_rst_rel");
        run(1'b0, mk(0, 1, 0, 1, 0, 8'h00, 8'h01, 0, 0, 1, 0), "a_new_edge");
        run(1'b0, mk(0, 0, 0, 1, 0, 8'h00, 8'h01, 0, 0, 1, 0), "a_new_rel");
`endif

        // Day field: saturating limits and range-checked loads.
        run(1'b1, mk(1, 0, 0, 0, 0, 8'h00, 8'h01, 0, 0, 0, 0), "b_reset");
        run(1'b1, mk(0, 0, 0, 0, 0, 8'h00, 8'h01, 0, 0, 0, 0), "b_idle");
        run(1'b1, mk(0, 0, 1, 1, 0, 8'h00, 8'h01, 0, 0, 1, 0), "b_sat_min");
        run(1'b1, mk(0, 0, 0, 1, 0, 8'h00, 8'h01, 0, 0, 1, 0), "b_rel");
        run(1'b1, mk(0, 1, 0, 1, 0, 8'h00, 8'h02, 0, 0, 1, 0), "b_up");
        run(1'b1, mk(0, 0, 0, 1, 0, 8'h00, 8'h02, 0, 0, 1, 0), "b_rel2");
        run(1'b1, mk(0, 0, 0, 0, 1, 8'h32, 8'h02, 0, 0, 1, 1), "b_load_above");
        run(1'b1, mk(0, 0, 0, 0, 1, 8'h00, 8'h02, 0, 0, 1, 1), "b_load_below");
        run(1'b1, mk(0, 0, 0, 0, 1, 8'h31, 8'h31, 0, 0, 0, 0), "b_load31");
        run(1'b1, mk(0, 0, 0, 1, 0, 8'h00, 8'h31, 0, 0, 0, 0), "b_enter");
        run(1'b1, mk(0, 1, 0, 1, 0, 8'h00, 8'h31, 0, 0, 1, 0), "b_sat_max");
        run(1'b1, mk(0, 0, 0, 1, 0, 8'h00, 8'h31, 0, 0, 1, 0), "b_rel3");
        run(1'b1, mk(0, 0, 1, 1, 0, 8'h00, 8'h30, 0, 0, 1, 0), "b_down");
        run(1'b1, mk(0, 0, 0, 1, 0, 8'h00, 8'h30, 0, 0, 1, 0), "b_rel4");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
